// File: rtl/uart_dbg_pkg.sv
// Shared constants for the UART debug capture path: buffer modes and default frame width.
package uart_dbg_pkg;

    localparam int unsigned FRAME_W_DEF = 9;

    localparam logic [1:0] MODE_LATEST = 2'd0;
    localparam logic [1:0] MODE_FIFO   = 2'd1;
    localparam logic [1:0] MODE_RING   = 2'd2;

    // Modes that route frame_valid into the history buffer; reserved mode 3 does not.
    function automatic logic mode_buffers(input logic [1:0] mode);
        return (mode == MODE_FIFO) || (mode == MODE_RING);
    endfunction

endpackage

// File: rtl/uart_dbg_ram.sv
// DEPTH x FRAME_W history storage: one synchronous write port, one asynchronous read port, no reset.
module uart_dbg_ram
    import uart_dbg_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [FRAME_W-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [FRAME_W-1:0]         o_rdata
);

    logic [FRAME_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_logger.sv
// Capture buffer for received UART frames: latest-frame register plus a FIFO/RING history
// buffer drained through a valid/ready port, with a saturating count of lost frames.
module uart_frame_logger
    import uart_dbg_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FRAME_W-1:0]         i_frame,
    input  logic                       i_frame_valid,
    input  logic [1:0]                 i_mode,
    input  logic                       i_clear,
    input  logic                       i_rd_ready,
    output logic                       o_rd_valid,
    output logic [FRAME_W-1:0]         o_rd_data,
    output logic [FRAME_W-1:0]         o_last_frame,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic [CNT_W-1:0]           o_drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_full;
    logic               r_rd_valid;
    logic [CNT_W-1:0]   r_drop_count;
    logic [FRAME_W-1:0] r_last_frame;
    logic [FRAME_W-1:0] r_rd_hold;

    logic               w_pop;
    logic               w_accept;
    logic               w_overwrite;
    logic               w_drop;
    logic               w_we;
    logic [PTR_W-1:0]   w_wr_ptr_nxt;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [FRAME_W-1:0] w_mem_rdata;

    uart_dbg_ram #(
        .FRAME_W (FRAME_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_frame),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    // Push/pop/overwrite decision; a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        w_pop        = 1'b0;
        w_accept     = 1'b0;
        w_overwrite  = 1'b0;
        w_drop       = 1'b0;
        w_we         = 1'b0;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (!i_clear) begin
            w_pop = r_rd_valid && i_rd_ready;
            if (i_frame_valid && mode_buffers(i_mode)) begin
                if (!r_full || w_pop) begin
                    w_accept = 1'b1;
                end else if (i_mode == MODE_RING) begin
                    w_overwrite = 1'b1;
                    w_drop      = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end
            w_we = w_accept || w_overwrite;
            if (w_we) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop || w_overwrite) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            end
            if (w_accept && !w_pop) begin
                w_level_nxt = r_level + LVL_W'(1);
            end else if (w_pop && !w_accept) begin
                w_level_nxt = r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_full       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_drop_count <= '0;
            r_last_frame <= '0;
            r_rd_hold    <= '0;
        end else if (i_clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_full       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_drop_count <= '0;
            r_last_frame <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LVL_W'(DEPTH));
            r_rd_valid <= (w_level_nxt != '0);
            if (i_frame_valid) begin
                r_last_frame <= i_frame;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
            // Remember the popped word so rd_data stays stable once the buffer empties.
            if (w_pop) begin
                r_rd_hold <= w_mem_rdata;
            end
        end
    end

    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_valid ? w_mem_rdata : r_rd_hold;
    assign o_last_frame = r_last_frame;
    assign o_level      = r_level;
    assign o_full       = r_full;
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_uart_frame_logger.sv
// Directed self-checking bench for uart_frame_logger; a second instance with CNT_W=2 covers saturation.
module tb_uart_frame_logger;

    localparam int unsigned FW = 9;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] frame;
    logic          frame_valid;
    logic [1:0]    mode;
    logic          clear;
    logic          rd_ready;

    logic          rd_valid;
    logic [FW-1:0] rd_data;
    logic [FW-1:0] last_frame;
    logic [3:0]    level;
    logic          full;
    logic [7:0]    drop_count;

    logic          s_rd_valid;
    logic [FW-1:0] s_rd_data;
    logic [FW-1:0] s_last_frame;
    logic [3:0]    s_level;
    logic          s_full;
    logic [1:0]    s_drop_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_frame_logger #(.FRAME_W(FW), .DEPTH(DP), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_frame(frame), .i_frame_valid(frame_valid),
        .i_mode(mode), .i_clear(clear), .i_rd_ready(rd_ready),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_last_frame(last_frame),
        .o_level(level), .o_full(full), .o_drop_count(drop_count)
    );

    uart_frame_logger #(.FRAME_W(FW), .DEPTH(DP), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .i_frame(frame), .i_frame_valid(frame_valid),
        .i_mode(mode), .i_clear(clear), .i_rd_ready(rd_ready),
        .o_rd_valid(s_rd_valid), .o_rd_data(s_rd_data), .o_last_frame(s_last_frame),
        .o_level(s_level), .o_full(s_full), .o_drop_count(s_drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [FW-1:0] f);
        frame       = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [FW-1:0] exp);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame = '0; frame_valid = 1'b0; mode = 2'd1; clear = 1'b0; rd_ready = 1'b0;
        tick(); tick();
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_last", 32'(last_frame), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        rst = 1'b0;
        tick();

        // Single push then pop
        mode = 2'd1;
        push(9'h1A5);
        chk("single_rd_valid", 32'(rd_valid), 32'd1);
        chk("single_rd_data", 32'(rd_data), 32'h1A5);
        chk("single_level", 32'(level), 32'd1);
        chk("single_last", 32'(last_frame), 32'h1A5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("single_pop_valid", 32'(rd_valid), 32'd0);
        chk("single_pop_level", 32'(level), 32'd0);
        chk("single_hold_data", 32'(rd_data), 32'h1A5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("empty_ready_level", 32'(level), 32'd0);
        chk("empty_ready_data", 32'(rd_data), 32'h1A5);

        // FIFO overflow: 10 pushes into 8 entries
        for (int i = 1; i <= 10; i++) push(FW'(i));
        chk("fifo_full", 32'(full), 32'd1);
        chk("fifo_level", 32'(level), 32'd8);
        chk("fifo_drop", 32'(drop_count), 32'd2);
        chk("fifo_last", 32'(last_frame), 32'h00A);
        for (int i = 1; i <= 8; i++) pop_chk("fifo_drain", FW'(i));
        chk("fifo_drained_level", 32'(level), 32'd0);
        chk("fifo_drained_full", 32'(full), 32'd0);

        // RING overwrite
        do_clear();
        chk("clr_drop", 32'(drop_count), 32'd0);
        mode = 2'd2;
        for (int i = 1; i <= 10; i++) push(FW'(i));
        chk("ring_full", 32'(full), 32'd1);
        chk("ring_level", 32'(level), 32'd8);
        chk("ring_drop", 32'(drop_count), 32'd2);
        for (int i = 3; i <= 10; i++) pop_chk("ring_drain", FW'(i));
        chk("ring_drained_valid", 32'(rd_valid), 32'd0);

        // Push and pop together while full in FIFO mode
        do_clear();
        mode = 2'd1;
        for (int i = 1; i <= 8; i++) push(FW'(i));
        chk("pp_pre_full", 32'(full), 32'd1);
        frame = 9'h0FF; frame_valid = 1'b1; rd_ready = 1'b1;
        tick();
        frame_valid = 1'b0; rd_ready = 1'b0;
        chk("pp_level", 32'(level), 32'd8);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_drop", 32'(drop_count), 32'd0);
        for (int i = 2; i <= 8; i++) pop_chk("pp_drain", FW'(i));
        pop_chk("pp_drain_last", 9'h0FF);
        chk("pp_empty", 32'(rd_valid), 32'd0);

        // LATEST and reserved mode leave the buffer alone, but data stays readable
        push(9'h011);
        mode = 2'd0;
        push(9'h155);
        chk("latest_last", 32'(last_frame), 32'h155);
        chk("latest_level", 32'(level), 32'd1);
        chk("latest_rd_data", 32'(rd_data), 32'h011);
        mode = 2'd3;
        push(9'h0AA);
        chk("rsvd_last", 32'(last_frame), 32'h0AA);
        chk("rsvd_level", 32'(level), 32'd1);
        mode = 2'd1;
        frame = 9'h077; frame_valid = 1'b1; clear = 1'b1;
        tick();
        frame_valid = 1'b0; clear = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_valid", 32'(rd_valid), 32'd0);
        chk("clr_last", 32'(last_frame), 32'd0);
        chk("clr_drop2", 32'(drop_count), 32'd0);
        chk("clr_full", 32'(full), 32'd0);

        // Drop counter saturation on the CNT_W=2 instance
        for (int i = 1; i <= 8; i++) push(FW'(i));
        for (int i = 0; i < 5; i++) push(FW'(32 + i));
        chk("sat_drop_wide", 32'(drop_count), 32'd5);
        chk("sat_drop_narrow", 32'(s_drop_count), 32'd3);
        push(9'h1FF);
        chk("sat_hold_narrow", 32'(s_drop_count), 32'd3);
        chk("sat_hold_wide", 32'(drop_count), 32'd6);
        chk("sat_last", 32'(s_last_frame), 32'h1FF);

        // Asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_drop", 32'(drop_count), 32'd0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
